// File: rtl/varredura_display_paginas.sv
// Time-multiplexed anode scanner for an N-digit 7-segment display with two
// alternating pages (placar = page 0, cronometro = page 1).
// Optional feature macro: SCAN_BLANK_EN (anti-ghosting blank at end of each slot).
//
// The tick/digit/page/frame registers hold the scan position that the next
// enabled edge will present. That edge copies the position into the registered
// outputs and advances the counters, which gives the one-cycle load latency
// after reset and lets a disabled scan resume exactly where it stopped.
module varredura_display_paginas #(
  parameter int unsigned            N_DIGITS     = 4,
  parameter int unsigned            SCAN_DIV     = 50000,
  parameter int unsigned            PAGE_FRAMES  = 250,
  parameter logic [N_DIGITS-1:0]    PLACAR_MASK  = {N_DIGITS{1'b1}},
  parameter logic [N_DIGITS-1:0]    CRON_MASK    = N_DIGITS'(4'b0110),
  parameter int unsigned            BLANK_CYCLES = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        force_page_en,
  input  logic                        force_page,
  output logic [N_DIGITS-1:0]         anodo,
  output logic [$clog2(N_DIGITS)-1:0] digit_sel,
  output logic                        page,
  output logic                        frame_start
);

  localparam int unsigned DW = $clog2(N_DIGITS);
  localparam int unsigned TW = $clog2(SCAN_DIV);
  localparam int unsigned FW = $clog2(PAGE_FRAMES) + 1;
  localparam logic [N_DIGITS-1:0] MSB_ONE = {1'b1, {(N_DIGITS-1){1'b0}}};

  // Reject configurations the scanner cannot represent.
  if (N_DIGITS < 2 || SCAN_DIV < 2 || PAGE_FRAMES < 1 || BLANK_CYCLES >= SCAN_DIV) begin : g_bad_cfg
    $error("varredura_display_paginas: invalid parameter set");
  end

  logic [TW-1:0] tick, tick_nxt;
  logic [DW-1:0] pos_digit, digit_nxt;
  logic          pos_page, page_nxt;
  logic [FW-1:0] frames, frames_nxt;

  logic [N_DIGITS-1:0] anodo_c;
  logic                frame_start_c;
  logic                last_tick;
  logic                last_digit;

  // Scan position advance, page alternation and force sampling at frame boundary.
  always_comb begin
    tick_nxt   = tick;
    digit_nxt  = pos_digit;
    page_nxt   = pos_page;
    frames_nxt = frames;
    last_tick  = (tick == TW'(SCAN_DIV - 1));
    last_digit = (pos_digit == DW'(N_DIGITS - 1));
    if (enable) begin
      if (last_tick) begin
        tick_nxt = '0;
        if (last_digit) begin
          digit_nxt = '0;
          if (force_page_en) begin
            page_nxt   = force_page;
            frames_nxt = '0;
          end else if (frames == FW'(PAGE_FRAMES - 1)) begin
            page_nxt   = ~pos_page;
            frames_nxt = '0;
          end else begin
            frames_nxt = frames + FW'(1);
          end
        end else begin
          digit_nxt = pos_digit + DW'(1);
        end
      end else begin
        tick_nxt = tick + TW'(1);
      end
    end
  end

  // Anode pattern and frame marker for the position about to be presented.
  always_comb begin
    anodo_c       = ~((MSB_ONE >> pos_digit) & (pos_page ? CRON_MASK : PLACAR_MASK));
`ifdef SCAN_BLANK_EN
    if (tick >= TW'(SCAN_DIV - BLANK_CYCLES)) begin
      anodo_c = '1;
    end
`endif
    frame_start_c = (tick == '0) && (pos_digit == '0);
  end

  // Position counters and registered outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tick        <= '0;
      pos_digit   <= '0;
      pos_page    <= 1'b0;
      frames      <= '0;
      anodo       <= '1;
      digit_sel   <= '0;
      page        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      tick      <= tick_nxt;
      pos_digit <= digit_nxt;
      pos_page  <= page_nxt;
      frames    <= frames_nxt;
      if (enable) begin
        anodo       <= anodo_c;
        digit_sel   <= pos_digit;
        page        <= pos_page;
        frame_start <= frame_start_c;
      end else begin
        anodo       <= '1;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_varredura_display_paginas.sv
// Scoreboard bench for varredura_display_paginas (N=4, SCAN_DIV=4, PAGE_FRAMES=2).
module tb_varredura_display_paginas;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int PF  = 2;
`ifdef SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif
  localparam logic [3:0] M_PLACAR = 4'b1111;
  localparam logic [3:0] M_CRON   = 4'b0110;

  typedef struct packed {
    logic [3:0] an;
    logic [1:0] ds;
    logic       pg;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       force_page_en = 1'b0;
  logic       force_page = 1'b0;
  logic [3:0] anodo;
  logic [1:0] digit_sel;
  logic       page;
  logic       frame_start;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  // Reference model state: cycle index within frame, page and frames spent on it.
  int   m_pos = 0;
  int   m_page = 0;
  int   m_frames = 0;
  exp_t m_last = '{an: 4'b1111, ds: 2'd0, pg: 1'b0, fs: 1'b0};

  varredura_display_paginas #(
    .N_DIGITS(N), .SCAN_DIV(DIV), .PAGE_FRAMES(PF),
    .PLACAR_MASK(M_PLACAR), .CRON_MASK(M_CRON), .BLANK_CYCLES(BLANK + 1 - 1 + ((BLANK == 0) ? 1 : 0))
  ) dut (
    .clock(clk), .reset_n(reset_n), .enable(enable),
    .force_page_en(force_page_en), .force_page(force_page),
    .anodo(anodo), .digit_sel(digit_sel), .page(page), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and predict the outputs after the coming edge.
  task automatic step(input logic rn, input logic en, input logic fe, input logic fp);
    exp_t e;
    logic [3:0] mask;
    int digit;
    int tk;
    @(negedge clk);
    reset_n = rn; enable = en; force_page_en = fe; force_page = fp;
    if (!rn) begin
      m_pos = 0; m_page = 0; m_frames = 0;
      e = '{an: 4'b1111, ds: 2'd0, pg: 1'b0, fs: 1'b0};
    end else if (!en) begin
      e = m_last;
      e.an = 4'b1111;
      e.fs = 1'b0;
    end else begin
      digit = m_pos / DIV;
      tk    = m_pos % DIV;
      mask  = (m_page != 0) ? M_CRON : M_PLACAR;
      e.an  = 4'b1111;
      if (mask[N-1-digit]) e.an[N-1-digit] = 1'b0;
      if (BLANK > 0 && tk >= DIV - BLANK) e.an = 4'b1111;
      e.ds = 2'(digit);
      e.pg = 1'(m_page);
      e.fs = (m_pos == 0);
      m_pos++;
      if (m_pos == N * DIV) begin
        m_pos = 0;
        if (fe) begin
          m_page = int'(fp);
          m_frames = 0;
        end else begin
          m_frames++;
          if (m_frames == PF) begin
            m_page = 1 - m_page;
            m_frames = 0;
          end
        end
      end
    end
    m_last = e;
    q.push_back(e);
  endtask

  // Monitor: compare every presented output word against the scoreboard head.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (anodo !== e.an || digit_sel !== e.ds || page !== e.pg || frame_start !== e.fs) begin
        fails++;
        $display("FAIL cycle_out t=%0t: got anodo=%b digit_sel=%0d page=%b frame_start=%b, expected anodo=%b digit_sel=%0d page=%b frame_start=%b",
                 $time, anodo, digit_sel, page, frame_start, e.an, e.ds, e.pg, e.fs);
      end
    end
  end

  initial begin
    logic rn, en, fe, fp;
    // Reset, then free run across two page changes.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    // Disable mid-slot, then resume.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    // Force page 1 from mid-frame for several frames.
    for (int i = 0; i < 70; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    // Single-cycle reset mid-page, then restart.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    // Randomized traffic.
    fe = 1'b0; fp = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 29) == 0) fe = ~fe;
      if ($urandom_range(0, 9) == 0) fp = 1'($urandom_range(0, 1));
      step(rn, en, fe, fp);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
